// File: rtl/wwm_turn_sched_if.sv
// -----------------------------------------------------------------------------
// wwm_turn_sched_if
//
// Purpose:
//   Link between the turn scheduler and the shared projectile animator.
//   The scheduler launches a shot with its velocity and launch origin.
//   The animator reports when the shot is over and whether it struck the
//   opposing player.
//
// Signals:
//   anim_start  scheduler -> animator  one-cycle launch pulse
//   vX, vY      scheduler -> animator  latched launch velocity (4 bits each)
//   X_INITIAL   scheduler -> animator  launch origin X (10 bits)
//   Y_INITIAL   scheduler -> animator  launch origin Y (10 bits)
//   anim_done   animator -> scheduler  one-cycle end-of-flight pulse
//   hit         animator -> scheduler  qualifies anim_done: opponent struck
//
// Modports:
//   master  scheduler side
//   slave   animator side
// -----------------------------------------------------------------------------
interface wwm_turn_sched_if;
    logic       anim_start;
    logic [3:0] vX;
    logic [3:0] vY;
    logic [9:0] X_INITIAL;
    logic [9:0] Y_INITIAL;
    logic       anim_done;
    logic       hit;

    modport master (
        output anim_start,
        output vX,
        output vY,
        output X_INITIAL,
        output Y_INITIAL,
        input  anim_done,
        input  hit
    );

    modport slave (
        input  anim_start,
        input  vX,
        input  vY,
        input  X_INITIAL,
        input  Y_INITIAL,
        output anim_done,
        output hit
    );
endinterface

// File: rtl/wwm_turn_sched.sv
// -----------------------------------------------------------------------------
// wwm_turn_sched
//
// Purpose:
//   Turn scheduler for World War Math.  Player 1 and Player 2 share one
//   projectile animator, and this block decides whose turn it is.
//   Each turn runs in this order:
//     - aim with the switches
//     - launch one shot from the shooter's origin
//     - wait for the animator to finish, or for the flight timeout
//     - credit a hit and pause so the score can be seen
//     - pass the turn to the other player, or declare a winner
//
// Ports:
//   clk         system clock
//   Reset_n     asynchronous active-low reset
//   Start       start/restart button level (already synchronised)
//   Fire        fire button level (already synchronised)
//   Sw[7:0]     velocity switches, [7:4] = vX, [3:0] = vY
//   bus         animator link (master side): anim_start, vX, vY,
//               X_INITIAL, Y_INITIAL out; anim_done, hit in
//   shooter     current shooter, 0 = P1, 1 = P2
//   score_p1    Player 1 hit count
//   score_p2    Player 2 hit count
//   winner      winning player, meaningful while q_Done is high
//   q_I, q_Aim, q_Launch, q_Flight, q_Resolve, q_Done
//               one-hot state flags
// -----------------------------------------------------------------------------
module wwm_turn_sched #(
    parameter logic [9:0]  P1_X           = 10'd213,
    parameter logic [9:0]  P1_Y           = 10'd472,
    parameter logic [9:0]  P2_X           = 10'd571,
    parameter logic [9:0]  P2_Y           = 10'd472,
    parameter logic [3:0]  WIN_SCORE      = 4'd3,
    parameter logic [31:0] FLIGHT_TIMEOUT = 32'd400_000_000,
    parameter logic [31:0] RESOLVE_HOLD   = 32'd50_000_000
) (
    input  logic                    clk,
    input  logic                    Reset_n,
    input  logic                    Start,
    input  logic                    Fire,
    input  logic [7:0]              Sw,
    wwm_turn_sched_if.master        bus,
    output logic                    shooter,
    output logic [3:0]              score_p1,
    output logic [3:0]              score_p2,
    output logic                    winner,
    output logic                    q_I,
    output logic                    q_Aim,
    output logic                    q_Launch,
    output logic                    q_Flight,
    output logic                    q_Resolve,
    output logic                    q_Done
);

    // One-hot encoding: each state flag is a state register bit, so the
    // flags come straight from flops and exactly one is ever high.
    typedef enum logic [5:0] {
        ST_I       = 6'b000001,
        ST_AIM     = 6'b000010,
        ST_LAUNCH  = 6'b000100,
        ST_FLIGHT  = 6'b001000,
        ST_RESOLVE = 6'b010000,
        ST_DONE    = 6'b100000
    } state_t;

    state_t      state;
    logic        start_d;
    logic        start_evt;
    logic        fire_d;
    logic        fire_evt;
    logic [31:0] cnt;
    logic        anim_start_r;
    logic [3:0]  vx_r;
    logic [3:0]  vy_r;
    logic [9:0]  x_init_r;
    logic [9:0]  y_init_r;
    logic        shooter_r;
    logic [3:0]  score_p1_r;
    logic [3:0]  score_p2_r;
    logic        winner_r;

    // Adds a hit to a score but never goes past the winning score.
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN_SCORE) ? s : s + 4'd1;
    endfunction

    // Rising-edge detectors for the two buttons.  Each event lasts one cycle.
    // The cycle after the button's 0->1 transition is registered, so holding
    // a button down produces only one event.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            start_d   <= 1'b0;
            start_evt <= 1'b0;
            fire_d    <= 1'b0;
            fire_evt  <= 1'b0;
        end else begin
            start_d   <= Start;
            start_evt <= Start & ~start_d;
            fire_d    <= Fire;
            fire_evt  <= Fire & ~fire_d;
        end
    end

    // The launch origin is a registered copy of the shooter's fixed
    // position.  It follows a change of shooter one cycle later.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_init_r <= P1_X;
            y_init_r <= P1_Y;
        end else begin
            x_init_r <= shooter_r ? P2_X : P1_X;
            y_init_r <= shooter_r ? P2_Y : P1_Y;
        end
    end

    // Turn sequencer.  One counter serves two purposes, because only one
    // state uses it at a time:
    //   - in FLIGHT it times the shot against the timeout
    //   - in RESOLVE it times the score pause
    // anim_start is set only on the edge that enters LAUNCH, so it is high
    // for exactly that single cycle.  Reset clears it without delay.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= ST_I;
            cnt          <= 32'd0;
            anim_start_r <= 1'b0;
            vx_r         <= 4'd0;
            vy_r         <= 4'd0;
            shooter_r    <= 1'b0;
            score_p1_r   <= 4'd0;
            score_p2_r   <= 4'd0;
            winner_r     <= 1'b0;
        end else begin
            anim_start_r <= 1'b0;
            case (state)
                ST_I: begin
                    if (start_evt) begin
                        score_p1_r <= 4'd0;
                        score_p2_r <= 4'd0;
                        shooter_r  <= 1'b0;
                        state      <= ST_AIM;
                    end
                end

                // The velocity follows the switches live while aiming.
                // It freezes on the fire cycle because this state is left
                // on that same edge.  A zero velocity would be a shot that
                // never moves, so it is rejected.
                ST_AIM: begin
                    vx_r <= Sw[7:4];
                    vy_r <= Sw[3:0];
                    if (fire_evt && (Sw != 8'd0)) begin
                        anim_start_r <= 1'b1;
                        state        <= ST_LAUNCH;
                    end
                end

                ST_LAUNCH: begin
                    cnt   <= 32'd0;
                    state <= ST_FLIGHT;
                end

                // anim_done takes priority over the timeout.  A shot that
                // finishes on the very last cycle still counts its hit.
                ST_FLIGHT: begin
                    if (bus.anim_done) begin
                        if (bus.hit) begin
                            if (shooter_r) begin
                                score_p2_r <= sat_inc(score_p2_r);
                            end else begin
                                score_p1_r <= sat_inc(score_p1_r);
                            end
                        end
                        cnt   <= 32'd0;
                        state <= ST_RESOLVE;
                    end else if (cnt == FLIGHT_TIMEOUT - 32'd1) begin
                        cnt   <= 32'd0;
                        state <= ST_RESOLVE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                // Scores are already final on entry to RESOLVE, so the win
                // test can use the registered values.  Only the shooter can
                // score, so at most one player reaches the winning score.
                ST_RESOLVE: begin
                    if (cnt == RESOLVE_HOLD - 32'd1) begin
                        cnt <= 32'd0;
                        if (score_p1_r == WIN_SCORE) begin
                            winner_r <= 1'b0;
                            state    <= ST_DONE;
                        end else if (score_p2_r == WIN_SCORE) begin
                            winner_r <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            shooter_r <= ~shooter_r;
                            state     <= ST_AIM;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                ST_DONE: begin
                    if (start_evt) begin
                        state <= ST_I;
                    end
                end

                default: begin
                    state <= ST_I;
                end
            endcase
        end
    end

    assign bus.anim_start = anim_start_r;
    assign bus.vX         = vx_r;
    assign bus.vY         = vy_r;
    assign bus.X_INITIAL  = x_init_r;
    assign bus.Y_INITIAL  = y_init_r;

    assign shooter   = shooter_r;
    assign score_p1  = score_p1_r;
    assign score_p2  = score_p2_r;
    assign winner    = winner_r;

    assign q_I       = state[0];
    assign q_Aim     = state[1];
    assign q_Launch  = state[2];
    assign q_Flight  = state[3];
    assign q_Resolve = state[4];
    assign q_Done    = state[5];

endmodule

// File: tb/tb_wwm_turn_sched.sv
// -----------------------------------------------------------------------------
// tb_wwm_turn_sched
//
// Purpose:
//   Drives the turn scheduler through a full game with directed vectors.
//   A small game-rules model runs next to the DUT.  It keeps the phase as a
//   plain number and counts down the cycles left in that phase.  Every clock
//   the DUT outputs are compared with the model's expected outputs.
//   Hand-computed literal checks at key points pin the model itself.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_wwm_turn_sched;

    localparam logic [9:0] TB_P1_X   = 10'd213;
    localparam logic [9:0] TB_P1_Y   = 10'd472;
    localparam logic [9:0] TB_P2_X   = 10'd571;
    localparam logic [9:0] TB_P2_Y   = 10'd472;
    localparam logic [3:0] TB_WIN    = 4'd2;
    localparam int         TB_TMO    = 20;
    localparam int         TB_HOLD   = 4;

    localparam int PH_I = 0, PH_AIM = 1, PH_LAUNCH = 2;
    localparam int PH_FLIGHT = 3, PH_RESOLVE = 4, PH_DONE = 5;

    logic       clk;
    logic       Reset_n;
    logic       Start;
    logic       Fire;
    logic [7:0] Sw;
    logic       shooter;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       winner;
    logic       q_I, q_Aim, q_Launch, q_Flight, q_Resolve, q_Done;
    logic [5:0] qv;

    int checks = 0;
    int errors = 0;

    wwm_turn_sched_if bus ();

    wwm_turn_sched #(
        .P1_X           (TB_P1_X),
        .P1_Y           (TB_P1_Y),
        .P2_X           (TB_P2_X),
        .P2_Y           (TB_P2_Y),
        .WIN_SCORE      (TB_WIN),
        .FLIGHT_TIMEOUT (32'd20),
        .RESOLVE_HOLD   (32'd4)
    ) dut (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Fire      (Fire),
        .Sw        (Sw),
        .bus       (bus.master),
        .shooter   (shooter),
        .score_p1  (score_p1),
        .score_p2  (score_p2),
        .winner    (winner),
        .q_I       (q_I),
        .q_Aim     (q_Aim),
        .q_Launch  (q_Launch),
        .q_Flight  (q_Flight),
        .q_Resolve (q_Resolve),
        .q_Done    (q_Done)
    );

    assign qv = {q_Done, q_Resolve, q_Flight, q_Launch, q_Aim, q_I};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Game-rules model.  Button history is kept as the last two sampled
    // levels.  A press is seen one clock after it is first sampled.
    typedef struct {
        int         phase;
        int         left;
        logic [3:0] vx;
        logic [3:0] vy;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       shooter;
        logic       winner;
        logic [9:0] x;
        logic [9:0] y;
        logic       st1, st2, fi1, fi2;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.phase = PH_I;  r.left = 0;
        r.vx = 4'd0;     r.vy = 4'd0;
        r.p1 = 4'd0;     r.p2 = 4'd0;
        r.shooter = 1'b0; r.winner = 1'b0;
        r.x = TB_P1_X;   r.y = TB_P1_Y;
        r.st1 = 1'b0; r.st2 = 1'b0; r.fi1 = 1'b0; r.fi2 = 1'b0;
        return r;
    endfunction

    function automatic model_t model_next(model_t c, logic st, logic fi,
                                          logic [7:0] sw, logic dn, logic ht);
        model_t n = c;
        logic sev = c.st1 && !c.st2;
        logic fev = c.fi1 && !c.fi2;
        n.st2 = c.st1;  n.st1 = st;
        n.fi2 = c.fi1;  n.fi1 = fi;
        n.x = c.shooter ? TB_P2_X : TB_P1_X;
        n.y = c.shooter ? TB_P2_Y : TB_P1_Y;
        case (c.phase)
            PH_I: if (sev) begin
                n.phase = PH_AIM; n.p1 = 4'd0; n.p2 = 4'd0; n.shooter = 1'b0;
            end
            PH_AIM: begin
                n.vx = sw[7:4];
                n.vy = sw[3:0];
                if (fev && sw != 8'd0) n.phase = PH_LAUNCH;
            end
            PH_LAUNCH: begin
                n.phase = PH_FLIGHT;
                n.left  = TB_TMO;
            end
            PH_FLIGHT: begin
                if (dn) begin
                    if (ht && c.shooter && c.p2 < TB_WIN) n.p2 = c.p2 + 4'd1;
                    if (ht && !c.shooter && c.p1 < TB_WIN) n.p1 = c.p1 + 4'd1;
                    n.phase = PH_RESOLVE;
                    n.left  = TB_HOLD;
                end else begin
                    n.left = c.left - 1;
                    if (n.left == 0) begin
                        n.phase = PH_RESOLVE;
                        n.left  = TB_HOLD;
                    end
                end
            end
            PH_RESOLVE: begin
                n.left = c.left - 1;
                if (n.left == 0) begin
                    if (c.p1 == TB_WIN) begin
                        n.phase = PH_DONE; n.winner = 1'b0;
                    end else if (c.p2 == TB_WIN) begin
                        n.phase = PH_DONE; n.winner = 1'b1;
                    end else begin
                        n.shooter = ~c.shooter; n.phase = PH_AIM;
                    end
                end
            end
            default: if (sev) n.phase = PH_I;
        endcase
        return n;
    endfunction

    // The model advances on the same clock and reset as the DUT.
    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) m <= model_reset();
        else          m <= model_next(m, Start, Fire, Sw, bus.anim_done, bus.hit);
    end

    function automatic logic [44:0] model_vec(model_t c);
        logic [5:0] q;
        for (int i = 0; i < 6; i++) q[i] = (c.phase == i);
        return {q, c.phase == PH_LAUNCH, c.vx, c.vy, c.x, c.y,
                c.shooter, c.p1, c.p2, c.winner};
    endfunction

    function automatic logic [44:0] dut_vec();
        return {qv, bus.anim_start, bus.vX, bus.vY, bus.X_INITIAL,
                bus.Y_INITIAL, shooter, score_p1, score_p2, winner};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Advances one clock.  On the falling edge the DUT is compared with the
    // model, then the bench moves just past that edge to drive inputs.
    task automatic cyc();
        logic [44:0] got, want;
        @(negedge clk);
        if (Reset_n) begin
            got  = dut_vec();
            want = model_vec(m);
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL model_compare t=%0t: got %h, want %h",
                         $time, got, want);
            end
        end
        #1;
    endtask

    task automatic apply_stimulus(input logic st, input logic fi, input logic [7:0] sw,
                                  input logic dn, input logic ht);
        Start = st;
        Fire = fi;
        Sw = sw;
        bus.anim_done = dn;
        bus.hit = ht;
    endtask

    task automatic wait_state(input int idx, input int budget, input string name);
        int n = 0;
        while (!qv[idx] && n < budget) begin
            cyc();
            n++;
        end
        check_output(name, {31'd0, qv[idx]}, 32'd1);
    endtask

    task automatic press_start();
        Start = 1'b1;
        cyc();
        Start = 1'b0;
    endtask

    // One complete turn: fire, let the shot fly a cycle, end it with the
    // given hit flag, then wait for the next AIM or for DONE.
    task automatic play_turn(input logic [7:0] sw, input logic ht);
        apply_stimulus(1'b0, 1'b1, sw, 1'b0, 1'b0);
        cyc();
        Fire = 1'b0;
        wait_state(PH_FLIGHT, 10, "turn_reach_flight");
        cyc();
        bus.anim_done = 1'b1;
        bus.hit = ht;
        cyc();
        bus.anim_done = 1'b0;
        bus.hit = 1'b0;
        for (int i = 0; i < 20 && !(q_Aim || q_Done); i++) cyc();
        check_output("turn_end", {31'd0, q_Aim | q_Done}, 32'd1);
    endtask

    initial begin
        int n;
        int pulses;
        int flights;
        Reset_n = 1'b0;
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc();
        cyc();
        check_output("reset_q_I", {31'd0, q_I}, 32'd1);
        check_output("reset_anim_start", {31'd0, bus.anim_start}, 32'd0);
        check_output("reset_X_INITIAL", {22'd0, bus.X_INITIAL}, 32'd213);
        check_output("reset_Y_INITIAL", {22'd0, bus.Y_INITIAL}, 32'd472);
        Reset_n = 1'b1;

        // First turn: P1 aims 0x35, fires and hits.
        apply_stimulus(1'b1, 1'b0, 8'h35, 1'b0, 1'b0);
        cyc();
        cyc();
        Start = 1'b0;
        wait_state(PH_AIM, 10, "reach_aim");
        Fire = 1'b1;
        cyc();
        Fire = 1'b0;
        wait_state(PH_LAUNCH, 10, "reach_launch");
        check_output("launch_anim_start", {31'd0, bus.anim_start}, 32'd1);
        check_output("launch_vX", {28'd0, bus.vX}, 32'd3);
        check_output("launch_vY", {28'd0, bus.vY}, 32'd5);
        check_output("launch_X_INITIAL", {22'd0, bus.X_INITIAL}, 32'd213);
        check_output("launch_Y_INITIAL", {22'd0, bus.Y_INITIAL}, 32'd472);
        cyc();
        check_output("launch_one_cycle", {31'd0, q_Flight}, 32'd1);
        Sw = 8'hFF;
        repeat (3) cyc();
        check_output("flight_vX_frozen", {28'd0, bus.vX}, 32'd3);
        check_output("flight_vY_frozen", {28'd0, bus.vY}, 32'd5);
        bus.anim_done = 1'b1;
        bus.hit = 1'b1;
        cyc();
        bus.anim_done = 1'b0;
        bus.hit = 1'b0;
        check_output("hit_q_Resolve", {31'd0, q_Resolve}, 32'd1);
        check_output("hit_score_p1", {28'd0, score_p1}, 32'd1);
        n = 1;
        cyc();
        while (q_Resolve && n < 20) begin
            n++;
            cyc();
        end
        check_output("resolve_cycles", n, 32'd4);
        check_output("handover_q_Aim", {31'd0, q_Aim}, 32'd1);
        check_output("handover_shooter", {31'd0, shooter}, 32'd1);
        cyc();
        check_output("handover_X_INITIAL", {22'd0, bus.X_INITIAL}, 32'd571);

        // A fire press with all switches at zero is ignored.
        apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        cyc();
        Fire = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            pulses += int'(bus.anim_start);
        end
        check_output("zero_sw_pulses", pulses, 32'd0);
        check_output("zero_sw_stays_aim", {31'd0, q_Aim}, 32'd1);

        // Fire held for 10 cycles gives one launch.  The shot then times out.
        apply_stimulus(1'b0, 1'b1, 8'h92, 1'b0, 1'b0);
        pulses = 0;
        flights = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            pulses += int'(bus.anim_start);
            flights += int'(q_Flight);
        end
        Fire = 1'b0;
        for (int i = 0; i < 40 && !q_Resolve; i++) begin
            cyc();
            pulses += int'(bus.anim_start);
            flights += int'(q_Flight);
        end
        check_output("held_fire_pulses", pulses, 32'd1);
        check_output("timeout_flight_cycles", flights, 32'd20);
        check_output("timeout_q_Resolve", {31'd0, q_Resolve}, 32'd1);
        check_output("timeout_score_p1", {28'd0, score_p1}, 32'd1);
        check_output("timeout_score_p2", {28'd0, score_p2}, 32'd0);
        bus.anim_done = 1'b1;
        bus.hit = 1'b1;
        cyc();
        bus.anim_done = 1'b0;
        bus.hit = 1'b0;
        check_output("late_done_ignored", {28'd0, score_p2}, 32'd0);
        wait_state(PH_AIM, 10, "timeout_handover");
        check_output("timeout_shooter", {31'd0, shooter}, 32'd0);

        // P1 misses, P2 hits, P1 misses, P2 hits -> P2 wins with 2.
        play_turn(8'h11, 1'b0);
        play_turn(8'h21, 1'b1);
        play_turn(8'h13, 1'b0);
        play_turn(8'h24, 1'b1);
        check_output("done_q_Done", {31'd0, q_Done}, 32'd1);
        check_output("done_winner", {31'd0, winner}, 32'd1);
        check_output("done_score_p2", {28'd0, score_p2}, 32'd2);
        check_output("done_score_p1", {28'd0, score_p1}, 32'd1);
        Fire = 1'b1;
        cyc();
        Fire = 1'b0;
        repeat (3) cyc();
        check_output("done_fire_ignored", {31'd0, q_Done}, 32'd1);

        // Restart: Start goes to I, and a second Start begins a new game.
        press_start();
        wait_state(PH_I, 10, "restart_reach_I");
        check_output("idle_scores_held", {28'd0, score_p2}, 32'd2);
        cyc();
        press_start();
        wait_state(PH_AIM, 10, "restart_reach_aim");
        check_output("restart_score_p1", {28'd0, score_p1}, 32'd0);
        check_output("restart_score_p2", {28'd0, score_p2}, 32'd0);
        check_output("restart_shooter", {31'd0, shooter}, 32'd0);

        // P1 scores, then reset is applied mid-way through P2's flight.
        play_turn(8'h46, 1'b1);
        check_output("pre_reset_score_p1", {28'd0, score_p1}, 32'd1);
        apply_stimulus(1'b0, 1'b1, 8'h7A, 1'b0, 1'b0);
        cyc();
        Fire = 1'b0;
        wait_state(PH_FLIGHT, 10, "pre_reset_flight");
        cyc();
        #2;
        Reset_n = 1'b0;
        #1;
        check_output("async_reset_q_I", {31'd0, q_I}, 32'd1);
        check_output("async_reset_q_Flight", {31'd0, q_Flight}, 32'd0);
        check_output("async_reset_anim_start", {31'd0, bus.anim_start}, 32'd0);
        check_output("async_reset_vX", {28'd0, bus.vX}, 32'd0);
        check_output("async_reset_vY", {28'd0, bus.vY}, 32'd0);
        check_output("async_reset_score_p1", {28'd0, score_p1}, 32'd0);
        check_output("async_reset_shooter", {31'd0, shooter}, 32'd0);
        check_output("async_reset_X_INITIAL", {22'd0, bus.X_INITIAL}, 32'd213);
        cyc();
        Reset_n = 1'b1;
        cyc();
        press_start();
        wait_state(PH_AIM, 10, "recover_reach_aim");
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
